// File: rtl/pdp8_core.sv
// PDP-8 CPU core: AC/L/PC/IR/MQ datapath, control FSM and front-panel load/deposit/run.
// Define PDP8_EAE_EN to enable the group-3 MQ instructions; without it MQ is absent and reads 0.
module pdp8_core #(
    parameter logic [11:0] RESET_PC = 12'o0200
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [11:0] sw_data,
    input  logic        load_pc_btn,
    input  logic        deposit_btn,
    input  logic        run_sw,
    output logic [11:0] mem_address,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic [11:0] mem_write_data,
    input  logic [11:0] mem_read_data,
    input  logic        mem_finished,
    output logic        running,
    output logic [3:0]  curr_state,
    output logic [11:0] ac_out,
    output logic        link_out,
    output logic [11:0] pc_out,
    output logic [11:0] mq_out
);

    typedef enum logic [3:0] {
        ST_HALT    = 4'd0,
        ST_FETCH_1 = 4'd1,
        ST_FETCH_2 = 4'd2,
        ST_DEFER   = 4'd3,
        ST_AUTOINC = 4'd4,
        ST_EXEC_RD = 4'd5,
        ST_EXEC_WR = 4'd6,
        ST_EXEC    = 4'd7,
        ST_DEPOSIT = 4'd8
    } state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_TAD = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_DCA = 3'd3;
    localparam logic [2:0] OP_JMS = 3'd4;
    localparam logic [2:0] OP_JMP = 3'd5;
    localparam logic [2:0] OP_OPR = 3'd7;

    state_t      state_r, state_next_s;
    logic [11:0] ac_r, pc_r, ir_r, ea_r, mb_r;
    logic        link_r, running_r;
    logic [4:0]  page_r;
    logic        load_prev_r, dep_prev_r, run_prev_r;
    logic        load_edge_s, dep_edge_s, run_edge_s;
    logic        busy_s, done_s, issue_s, autoidx_s;
    logic [2:0]  op_s;
    logic [11:0] opr_ac_s;
    logic        opr_l_s, opr_skip_s, opr_halt_s, cond_s;
    logic [12:0] rot_s;
    logic        rd_next_s, wr_next_s;
    logic [11:0] addr_next_s, wdata_next_s;
`ifdef PDP8_EAE_EN
    logic [11:0] mq_r, opr_mq_s, base_s;
    assign mq_out = mq_r;
`else
    assign mq_out = 12'd0;
`endif

    assign load_edge_s = load_pc_btn & ~load_prev_r;
    assign dep_edge_s  = deposit_btn & ~dep_prev_r;
    assign run_edge_s  = run_sw & ~run_prev_r;
    assign busy_s      = mem_read_enable | mem_write_enable;
    assign done_s      = busy_s & mem_finished;
    assign issue_s     = ~busy_s;
    assign autoidx_s   = (ea_r[11:3] == 9'o001);
    assign op_s        = ir_r[11:9];
    assign running     = running_r;
    assign curr_state  = state_r;
    assign ac_out      = ac_r;
    assign link_out    = link_r;
    assign pc_out      = pc_r;

    // Memory-reference dispatch once the effective address is final.
    function automatic state_t route(input logic [2:0] op);
        case (op)
            OP_AND, OP_TAD, OP_ISZ: route = ST_EXEC_RD;
            OP_DCA, OP_JMS:         route = ST_EXEC_WR;
            default:                route = ST_EXEC;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_r <= ST_HALT;
        else         state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_HALT: begin
                if (load_edge_s)     state_next_s = ST_HALT;
                else if (dep_edge_s) state_next_s = ST_DEPOSIT;
                else if (run_edge_s) state_next_s = ST_FETCH_1;
                else                 state_next_s = ST_HALT;
            end
            ST_FETCH_1: state_next_s = ST_FETCH_2;
            ST_FETCH_2: begin
                if (!done_s)                           state_next_s = ST_FETCH_2;
                else if (mem_read_data[11:10] == 2'b11) state_next_s = ST_EXEC;
                else if (mem_read_data[8])             state_next_s = ST_DEFER;
                else                                   state_next_s = route(mem_read_data[11:9]);
            end
            ST_DEFER: begin
                if (!done_s)        state_next_s = ST_DEFER;
                else if (autoidx_s) state_next_s = ST_AUTOINC;
                else                state_next_s = route(op_s);
            end
            ST_AUTOINC: state_next_s = done_s ? route(op_s) : ST_AUTOINC;
            ST_EXEC_RD: begin
                if (!done_s)              state_next_s = ST_EXEC_RD;
                else if (op_s == OP_ISZ)  state_next_s = ST_EXEC_WR;
                else                      state_next_s = ST_EXEC;
            end
            ST_EXEC_WR: state_next_s = done_s ? ST_EXEC : ST_EXEC_WR;
            ST_EXEC:    state_next_s = (op_s == OP_OPR && opr_halt_s) ? ST_HALT : ST_FETCH_1;
            ST_DEPOSIT: state_next_s = done_s ? ST_HALT : ST_DEPOSIT;
            default:    state_next_s = ST_HALT;
        endcase
    end

    // Memory request: raise one enable a cycle after entering a memory state, drop it after mem_finished.
    always_comb begin
        rd_next_s    = mem_read_enable;
        wr_next_s    = mem_write_enable;
        addr_next_s  = mem_address;
        wdata_next_s = mem_write_data;
        if (done_s) begin
            rd_next_s = 1'b0;
            wr_next_s = 1'b0;
        end else if (issue_s) begin
            case (state_r)
                ST_FETCH_2: begin rd_next_s = 1'b1; addr_next_s = pc_r; end
                ST_DEFER, ST_EXEC_RD: begin rd_next_s = 1'b1; addr_next_s = ea_r; end
                ST_AUTOINC: begin
                    wr_next_s = 1'b1; addr_next_s = ea_r; wdata_next_s = mb_r + 12'd1;
                end
                ST_EXEC_WR: begin
                    wr_next_s   = 1'b1;
                    addr_next_s = ea_r;
                    wdata_next_s = (op_s == OP_DCA) ? ac_r :
                                   (op_s == OP_JMS) ? pc_r : mb_r + 12'd1;
                end
                ST_DEPOSIT: begin wr_next_s = 1'b1; addr_next_s = pc_r; wdata_next_s = mb_r; end
                default: begin rd_next_s = 1'b0; wr_next_s = 1'b0; end
            endcase
        end else begin
            rd_next_s = mem_read_enable;
            wr_next_s = mem_write_enable;
        end
    end

    // Operate-instruction result (groups 1, 2 and 3).
    always_comb begin
        opr_ac_s   = ac_r;
        opr_l_s    = link_r;
        opr_skip_s = 1'b0;
        opr_halt_s = 1'b0;
        cond_s     = 1'b0;
        rot_s      = {link_r, ac_r};
`ifdef PDP8_EAE_EN
        opr_mq_s = mq_r;
        base_s   = ir_r[7] ? 12'd0 : ac_r;
`endif
        if (!ir_r[8]) begin
            rot_s = {(ir_r[6] ? 1'b0 : link_r), (ir_r[7] ? 12'd0 : ac_r)};
            rot_s[11:0] = ir_r[5] ? ~rot_s[11:0] : rot_s[11:0];
            rot_s[12]   = ir_r[4] ? ~rot_s[12] : rot_s[12];
            rot_s       = ir_r[0] ? rot_s + 13'd1 : rot_s;
            case ({ir_r[3], ir_r[2]})
                2'b10:   rot_s = ir_r[1] ? {rot_s[1:0], rot_s[12:2]} : {rot_s[0], rot_s[12:1]};
                2'b01:   rot_s = ir_r[1] ? {rot_s[10:0], rot_s[12:11]} : {rot_s[11:0], rot_s[12]};
                2'b00:   rot_s[11:0] = ir_r[1] ? {rot_s[5:0], rot_s[11:6]} : rot_s[11:0];
                default: rot_s = rot_s;
            endcase
            opr_ac_s = rot_s[11:0];
            opr_l_s  = rot_s[12];
        end else if (!ir_r[0]) begin
            cond_s     = (ir_r[6] & ac_r[11]) | (ir_r[5] & (ac_r == 12'd0)) | (ir_r[4] & link_r);
            opr_skip_s = ir_r[3] ? ~cond_s : cond_s;
            opr_ac_s   = (ir_r[7] ? 12'd0 : ac_r) | (ir_r[2] ? sw_data : 12'd0);
            opr_halt_s = ir_r[1];
        end else begin
`ifdef PDP8_EAE_EN
            case ({ir_r[6], ir_r[4]})
                2'b11:   begin opr_ac_s = mq_r; opr_mq_s = base_s; end
                2'b10:   opr_ac_s = base_s | mq_r;
                2'b01:   begin opr_mq_s = base_s; opr_ac_s = 12'd0; end
                default: opr_ac_s = base_s;
            endcase
`else
            opr_ac_s = ir_r[7] ? 12'd0 : ac_r;
`endif
        end
    end

    // Registered memory interface.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= 12'd0;
            mem_write_data   <= 12'd0;
        end else begin
            mem_read_enable  <= rd_next_s;
            mem_write_enable <= wr_next_s;
            mem_address      <= addr_next_s;
            mem_write_data   <= wdata_next_s;
        end
    end

    // Datapath registers and panel edge detection.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ac_r <= 12'd0; link_r <= 1'b0; pc_r <= RESET_PC; ir_r <= 12'd0;
            ea_r <= 12'd0; mb_r <= 12'd0; page_r <= 5'd0; running_r <= 1'b0;
            load_prev_r <= 1'b0; dep_prev_r <= 1'b0; run_prev_r <= 1'b0;
`ifdef PDP8_EAE_EN
            mq_r <= 12'd0;
`endif
        end else begin
            load_prev_r <= load_pc_btn;
            dep_prev_r  <= deposit_btn;
            run_prev_r  <= run_sw;
            case (state_r)
                ST_HALT: begin
                    if (load_edge_s)     pc_r <= sw_data;
                    else if (dep_edge_s) mb_r <= sw_data;
                    else if (run_edge_s) running_r <= 1'b1;
                end
                ST_FETCH_1: page_r <= pc_r[11:7];
                ST_FETCH_2: if (done_s) begin
                    ir_r <= mem_read_data;
                    pc_r <= pc_r + 12'd1;
                    ea_r <= mem_read_data[7] ? {page_r, mem_read_data[6:0]}
                                             : {5'd0, mem_read_data[6:0]};
                end
                ST_DEFER: if (done_s) begin
                    mb_r <= mem_read_data;
                    if (!autoidx_s) ea_r <= mem_read_data;
                end
                ST_AUTOINC: if (done_s) ea_r <= mb_r + 12'd1;
                ST_EXEC_RD: if (done_s) mb_r <= mem_read_data;
                ST_DEPOSIT: if (done_s) pc_r <= pc_r + 12'd1;
                ST_EXEC: begin
                    case (op_s)
                        OP_AND: ac_r <= ac_r & mb_r;
                        OP_TAD: {link_r, ac_r} <= {link_r, ac_r} + {1'b0, mb_r};
                        OP_ISZ: if (mb_r == 12'o7777) pc_r <= pc_r + 12'd1;
                        OP_DCA: ac_r <= 12'd0;
                        OP_JMS: pc_r <= ea_r + 12'd1;
                        OP_JMP: pc_r <= ea_r;
                        OP_OPR: begin
                            ac_r   <= opr_ac_s;
                            link_r <= opr_l_s;
`ifdef PDP8_EAE_EN
                            mq_r   <= opr_mq_s;
`endif
                            if (opr_skip_s) pc_r <= pc_r + 12'd1;
                            if (opr_halt_s) running_r <= 1'b0;
                        end
                        default: ac_r <= ac_r;
                    endcase
                end
                default: ac_r <= ac_r;
            endcase
        end
    end

endmodule

// File: tb/tb_pdp8_core.sv
// Self-checking bench for pdp8_core: instruction-level reference model, panel tasks and a latency-varying memory.
module tb_pdp8_core;
    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [11:0] sw_data = 12'd0;
    logic        load_pc_btn = 1'b0, deposit_btn = 1'b0, run_sw = 1'b0;
    logic [11:0] mem_address, mem_write_data;
    logic        mem_read_enable, mem_write_enable;
    logic [11:0] mem_read_data = 12'd0;
    logic        mem_finished = 1'b0;
    logic        running;
    logic [3:0]  curr_state;
    logic [11:0] ac_out, pc_out, mq_out;
    logic        link_out;

    always #5 clock = ~clock;

    pdp8_core #(.RESET_PC(12'o0200)) dut (
        .clock(clock), .resetN(resetN), .sw_data(sw_data),
        .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn), .run_sw(run_sw),
        .mem_address(mem_address), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_finished(mem_finished),
        .running(running), .curr_state(curr_state), .ac_out(ac_out),
        .link_out(link_out), .pc_out(pc_out), .mq_out(mq_out)
    );

    logic [11:0] tb_mem [0:4095];
    int  m_mem [4096];
    int  m_ac, m_l, m_pc, m_mq;
    bit  m_halted = 1'b0;
    bit  checking = 1'b0;
    int  total = 0, bad = 0;
    int  lat_cnt = 0, lat_target = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %04o expected %04o", name, act, exp);
        end
    endtask

    function automatic int b(input int v, input int k);
        return (v >> k) & 1;
    endfunction

    // Executes one instruction on the architectural model.
    task automatic model_step();
        int ia, ir, op, ea, t, v, n;
        ia = m_pc; ir = m_mem[ia]; m_pc = (m_pc + 1) % 4096; op = ir / 512; ea = 0;
        if (op < 6) begin
            ea = ir % 128;
            if (b(ir, 7) == 1) ea = ea + (ia / 128) * 128;
            if (b(ir, 8) == 1) begin
                if (ea >= 8 && ea < 16) m_mem[ea] = (m_mem[ea] + 1) % 4096;
                ea = m_mem[ea];
            end
        end
        case (op)
            0: m_ac = m_ac & m_mem[ea];
            1: begin t = m_l * 4096 + m_ac + m_mem[ea]; m_l = (t / 4096) % 2; m_ac = t % 4096; end
            2: begin m_mem[ea] = (m_mem[ea] + 1) % 4096; if (m_mem[ea] == 0) m_pc = (m_pc + 1) % 4096; end
            3: begin m_mem[ea] = m_ac; m_ac = 0; end
            4: begin m_mem[ea] = m_pc; m_pc = (ea + 1) % 4096; end
            5: m_pc = ea;
            7: begin
                if (b(ir, 8) == 0) begin
                    if (b(ir, 7) == 1) m_ac = 0;
                    if (b(ir, 6) == 1) m_l = 0;
                    if (b(ir, 5) == 1) m_ac = 4095 - m_ac;
                    if (b(ir, 4) == 1) m_l = 1 - m_l;
                    if (b(ir, 0) == 1) begin t = m_l * 4096 + m_ac + 1; m_l = (t / 4096) % 2; m_ac = t % 4096; end
                    v = m_l * 4096 + m_ac;
                    n = (b(ir, 1) == 1) ? 2 : 1;
                    if (b(ir, 3) == 1 && b(ir, 2) == 0)
                        for (int k = 0; k < n; k++) v = v / 2 + (v % 2) * 4096;
                    else if (b(ir, 2) == 1 && b(ir, 3) == 0)
                        for (int k = 0; k < n; k++) v = (v * 2) % 8192 + v / 4096;
                    else if (b(ir, 3) == 0 && b(ir, 2) == 0 && b(ir, 1) == 1)
                        v = m_l * 4096 + (m_ac % 64) * 64 + m_ac / 64;
                    m_l = v / 4096; m_ac = v % 4096;
                end else if (b(ir, 0) == 0) begin
                    t = ((b(ir, 6) == 1 && m_ac >= 2048) || (b(ir, 5) == 1 && m_ac == 0) ||
                         (b(ir, 4) == 1 && m_l == 1)) ? 1 : 0;
                    if (b(ir, 3) == 1) t = 1 - t;
                    if (t == 1) m_pc = (m_pc + 1) % 4096;
                    if (b(ir, 7) == 1) m_ac = 0;
                    if (b(ir, 2) == 1) m_ac = m_ac | int'(sw_data);
                    if (b(ir, 1) == 1) m_halted = 1'b1;
                end else begin
                    if (b(ir, 7) == 1) m_ac = 0;
`ifdef PDP8_EAE_EN
                    if (b(ir, 6) == 1 && b(ir, 4) == 1) begin t = m_ac; m_ac = m_mq; m_mq = t; end
                    else if (b(ir, 6) == 1) m_ac = m_ac | m_mq;
                    else if (b(ir, 4) == 1) begin m_mq = m_ac; m_ac = 0; end
`endif
                end
            end
            default: ;
        endcase
    endtask

    // Memory responder: 0..2 cycles latency, one-cycle mem_finished pulse.
    always @(negedge clock) begin
        if (!resetN) begin
            mem_finished = 1'b0; lat_cnt = 0;
        end else if (mem_finished) begin
            mem_finished = 1'b0;
        end else if (mem_read_enable || mem_write_enable) begin
            if (lat_cnt < lat_target) lat_cnt++;
            else begin
                if (mem_write_enable) tb_mem[mem_address] = mem_write_data;
                else mem_read_data = tb_mem[mem_address];
                mem_finished = 1'b1; lat_cnt = 0; lat_target = (lat_target + 1) % 3;
            end
        end
    end

    // Compare process: handshake exclusivity each cycle, architectural state at every instruction fetch.
    always @(negedge clock) begin
        if (checking) begin
            check("rd_wr_exclusive", int'(mem_read_enable & mem_write_enable), 0);
            if (curr_state == 4'd1) begin
                check("fetch_pc", int'(pc_out), m_pc);
                check("fetch_ac", int'(ac_out), m_ac);
                check("fetch_link", int'(link_out), m_l);
                check("fetch_mq", int'(mq_out), m_mq);
                model_step();
            end
        end
    end

    task automatic poke(input int a, input int v);
        tb_mem[a] = 12'(v); m_mem[a] = v;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        m_pc = 'o200; m_ac = 0; m_l = 0; m_mq = 0;
    endtask

    task automatic load_pc(input int v);
        @(negedge clock); sw_data = 12'(v); load_pc_btn = 1'b1;
        @(negedge clock); load_pc_btn = 1'b0;
        repeat (2) @(negedge clock);
        m_pc = v;
    endtask

    task automatic deposit(input int v);
        @(negedge clock); sw_data = 12'(v); deposit_btn = 1'b1;
        @(negedge clock); deposit_btn = 1'b0;
        repeat (12) @(negedge clock);
        m_mem[m_pc] = v; m_pc = (m_pc + 1) % 4096;
    endtask

    task automatic check_mem(input string name);
        int idx = -1;
        for (int a = 0; a < 4096; a++)
            if (idx < 0 && int'(tb_mem[a]) != m_mem[a]) idx = a;
        total++;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s: mem[%04o] got %04o expected %04o", name, idx, tb_mem[idx], m_mem[idx]);
        end
    endtask

    task automatic run_prog(input string tag);
        int n = 0;
        m_halted = 1'b0; checking = 1'b1;
        @(negedge clock); run_sw = 1'b1;
        repeat (2) @(negedge clock); run_sw = 1'b0;
        check({tag, "_run_start"}, int'(running), 1);
        while (running && n < 3000) begin @(negedge clock); n++; end
        checking = 1'b0;
        check({tag, "_halt_in_time"}, int'(running), 0);
        check({tag, "_model_halted"}, int'(m_halted), 1);
        check({tag, "_pc"}, int'(pc_out), m_pc);
        check({tag, "_ac"}, int'(ac_out), m_ac);
        check({tag, "_link"}, int'(link_out), m_l);
        check({tag, "_mq"}, int'(mq_out), m_mq);
        check_mem({tag, "_mem"});
    endtask

    initial begin
        int n;
        for (int a = 0; a < 4096; a++) poke(a, 0);
        do_reset();
        check("rst_pc", int'(pc_out), 'o200);
        check("rst_ac", int'(ac_out), 0);
        check("rst_link", int'(link_out), 0);
        check("rst_mq", int'(mq_out), 0);
        check("rst_running", int'(running), 0);
        check("rst_state", int'(curr_state), 0);
        check("rst_rd", int'(mem_read_enable), 0);
        check("rst_wr", int'(mem_write_enable), 0);

        load_pc('o200); deposit('o1234); deposit('o5670);
        check("dep_mem200", int'(tb_mem['o200]), 'o1234);
        check("dep_mem201", int'(tb_mem['o201]), 'o5670);
        check("dep_pc", int'(pc_out), 'o202);
        check("dep_pc_model", int'(pc_out), m_pc);
        check("dep_running", int'(running), 0);

        poke('o200, 'o7300); poke('o201, 'o1210); poke('o202, 'o1211);
        poke('o203, 'o3212); poke('o204, 'o7402);
        poke('o210, 'o7777); poke('o211, 'o0002);
        load_pc('o200); run_prog("tad");
        check("tad_mem212", int'(tb_mem['o212]), 'o0001);
        check("tad_link", int'(link_out), 1);
        check("tad_ac", int'(ac_out), 0);
        check("tad_pc", int'(pc_out), 'o205);

        poke('o200, 'o7300); poke('o201, 'o1410); poke('o202, 'o7000); poke('o203, 'o4250);
        poke('o250, 0); poke('o251, 'o7402); poke('o10, 'o0277); poke('o300, 'o0055);
        load_pc('o200); run_prog("autoidx_jms");
        check("ai_mem10", int'(tb_mem['o10]), 'o0300);
        check("ai_ac", int'(ac_out), 'o0055);
        check("jms_mem250", int'(tb_mem['o250]), 'o0204);
        check("jms_pc", int'(pc_out), 'o252);

        poke('o200, 'o2220); poke('o201, 'o7402); poke('o202, 'o7300); poke('o203, 'o1221);
        poke('o204, 'o7500); poke('o205, 'o7402); poke('o206, 'o7510); poke('o207, 'o7402);
        poke('o210, 'o7402); poke('o220, 'o7777); poke('o221, 'o4000);
        load_pc('o200); run_prog("isz_skip");
        check("isz_mem220", int'(tb_mem['o220]), 0);
        check("skip_ac", int'(ac_out), 'o4000);
        check("skip_pc", int'(pc_out), 'o210);

        poke('o200, 'o7300); poke('o201, 'o1230); poke('o202, 'o7010); poke('o203, 'o7402);
        poke('o204, 'o7300); poke('o205, 'o1231); poke('o206, 'o7002); poke('o207, 'o7402);
        poke('o210, 'o7300); poke('o211, 'o1232); poke('o212, 'o7001); poke('o213, 'o7402);
        poke('o214, 'o7004); poke('o215, 'o7006); poke('o216, 'o7604); poke('o217, 'o7402);
        poke('o230, 'o0001); poke('o231, 'o0077); poke('o232, 'o7777);
        load_pc('o200); run_prog("rar");
        check("rar_ac", int'(ac_out), 0);
        check("rar_link", int'(link_out), 1);
        run_prog("bsw");
        check("bsw_ac", int'(ac_out), 'o7700);
        run_prog("iac");
        check("iac_ac", int'(ac_out), 0);
        check("iac_link", int'(link_out), 1);
        sw_data = 12'o5252;
        run_prog("ral_osr");
        check("osr_ac", int'(ac_out), 'o5252);
        check("osr_link", int'(link_out), 0);

        poke('o200, 'o7300); poke('o201, 'o1233); poke('o202, 'o7421); poke('o203, 'o7402);
        poke('o204, 'o7501); poke('o205, 'o7402); poke('o233, 'o1234);
        load_pc('o200); run_prog("mql");
`ifdef PDP8_EAE_EN
        check("mql_mq", int'(mq_out), 'o1234);
        check("mql_ac", int'(ac_out), 0);
`else
        check("mql_ac", int'(ac_out), 'o1234);
        check("mql_mq", int'(mq_out), 0);
`endif
        run_prog("mqa");
        check("mqa_ac", int'(ac_out), 'o1234);

        load_pc('o200);
        @(negedge clock); run_sw = 1'b1;
        @(negedge clock); run_sw = 1'b0;
        n = 0;
        while (!mem_read_enable && n < 20) begin @(negedge clock); n++; end
        check("midcyc_reached_read", int'(mem_read_enable), 1);
        #2 resetN = 1'b0;
        #1;
        check("midcyc_state", int'(curr_state), 0);
        check("midcyc_rd", int'(mem_read_enable), 0);
        check("midcyc_running", int'(running), 0);
        check("midcyc_pc", int'(pc_out), 'o200);
        check("midcyc_ac", int'(ac_out), 0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pdp8_core.md
Name: pdp8_core

Overview:
- PDP-8 processor core: CPU datapath (AC, L, PC, IR, MQ), control state machine and EAE/MQ unit, in one block.
- Sits between the front-panel block (switches/buttons, already debounced) and the 4K x 12 memory controller.
- Supports panel load-PC and deposit while halted.
- Runs programs from a run-switch edge until HLT.

Parameters:
- RESET_PC, 12'o0200, PC value after reset.

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- sw_data  in  12  panel switch register.
- load_pc_btn  in  1  level; rising edge loads PC.
- deposit_btn  in  1  level; rising edge deposits.
- run_sw  in  1  level; rising edge starts execution.
- mem_address  out  12  memory address.
- mem_read_enable  out  1  read request.
- mem_write_enable  out  1  write request.
- mem_write_data  out  12  write data.
- mem_read_data  in  12  read data, valid when mem_finished=1.
- mem_finished  in  1  one-cycle done pulse from memory.
- running  out  1  1 while executing (panel run LED).
- curr_state  out  4  state encoding, for trace/debug.
- ac_out  out  12  AC.
- link_out  out  1  L.
- pc_out  out  12  PC.
- mq_out  out  12  MQ.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low; ports are named clock and resetN.
  - Reset values: PC=RESET_PC; AC, L, MQ, IR = 0; state=HALT; all memory enables 0; running=0.
- Memory handshake:
  - Core holds address/data and exactly one enable high until the cycle mem_finished=1.
  - Core drops the enable on the next edge.
  - Read data is latched in the mem_finished cycle.
  - Read and write enables are never high together.
- States: HALT, FETCH_1, FETCH_2, DEFER, AUTOINC, EXEC_RD, EXEC_WR, EXEC.
- HALT:
  - load_pc_btn rising edge: PC=sw_data.
  - deposit_btn rising edge: write sw_data to mem[PC], then PC=PC+1 (wraps 7777->0000).
  - run_sw rising edge: go to FETCH_1 and set running=1.
  - Buttons are ignored while running.
  - Simultaneous edges have priority load > deposit > run.
- FETCH_1: issue read at PC; record instruction address IA=PC.
- FETCH_2: wait for mem_finished, then IR=data and PC=PC+1.
  - Opcode 6 (IOT) and 7 (OPR) go to EXEC.
  - Otherwise form EA: IR[7]=1 gives {IA[11:7],IR[6:0]}; IR[7]=0 gives {5'b0,IR[6:0]}.
- DEFER (IR[8]=1, opcodes 0-5): EA=mem[EA].
  - If the pointer address is 0010-0017 octal, go to AUTOINC first: write mem+1 back, then use the incremented value as EA.
- Memory-reference instructions:
  - AND: AC&=M.
  - TAD: {L,AC}=({L,AC}+M); carry out of AC complements L.
  - ISZ: write M+1; if the result is 0000, PC+=1.
  - DCA: write AC, then AC=0.
  - JMS: write PC to mem[EA], then PC=EA+1.
  - JMP: PC=EA, no memory cycle.
  - All arithmetic is modulo 4096.
- IOT: no operation.
- OPR group 1 (IR[8]=0), in this order:
  - CLA(IR7), CLL(IR6).
  - CMA(IR5), CML(IR4).
  - IAC(IR0), with carry into L.
  - Rotate through L: RAR(IR3)/RAL(IR2), one place, or two when IR1=1.
  - IR1=1 with no rotate bit: BSW (swap 6-bit halves).
  - RAR and RAL both set: no rotate.
- OPR group 2 (IR[8]=1, IR0=0):
  - Condition = SMA(IR6, AC[11]) OR SZA(IR5, AC==0) OR SNL(IR4, L).
  - IR3=1 inverts the sense: skip when every selected condition is false (SKP when none selected).
  - Skip means PC+=1.
  - Then CLA(IR7), then OSR(IR2): AC|=sw_data.
  - HLT(IR1): after the instruction completes, go to HALT and set running=0.
- OPR group 3 (IR[8]=1, IR0=1): handled by the EAE per Optional Feature.
- Non-halting instructions return to FETCH_1.
- resetN low at any point, including mid-memory-cycle, returns to HALT immediately.

Optional Feature:
- Macro: PDP8_EAE_EN.
- Defined — group 3 executes in this order:
  - CLA(IR7).
  - MQA(IR6) and MQL(IR4) together: swap AC and MQ.
  - MQA alone: AC|=MQ.
  - MQL alone: MQ=AC, then AC=0.
- Undefined: group 3 performs only CLA; MQ stays 0 and mq_out is tied 0.

Test Plan:
- Reset, panel load and deposit: reset; load_pc 0200; deposit 1234 and 5670 -> mem[0200]=1234, mem[0201]=5670, PC=0202, running=0.
- TAD carry: program at 0200 = 7300 (CLA CLL), 1210, 1211, 3212, 7402; mem[0210]=7777, mem[0211]=0002; load_pc 0200, run -> mem[0212]=0001, L=1, AC=0, running falls, PC=0205.
- Auto-index and JMS:
  - Case 1: mem[0010]=0277, instruction 1410 -> mem[0010]=0300; AC += mem[0300].
  - Case 2: JMS 0250 at 0203 -> mem[0250]=0204; execution continues at 0251.
- ISZ and group-2 skip:
  - ISZ on 7777 -> writes 0000 and skips.
  - 7500 (SMA) with AC=4000 -> skip; 7510 (SPA) with AC=4000 -> no skip.
- Rotates and group 1:
  - AC=0001, L=0: 7010 (RAR) -> AC=0000, L=1.
  - 7002 (BSW) on 0077 -> 7700.
  - 7001 on 7777, L=0 -> AC=0000, L=1.
- With PDP8_EAE_EN: AC=1234; 7421 (MQL) -> MQ=1234, AC=0; 7501 (MQA) -> AC=1234.
- Without PDP8_EAE_EN: 7421 -> AC unchanged.
